// File: rtl/ps2_key_mapper.sv
// PS/2 scan-code to KEY_PRESSED mapper for the player-direction block.
// Tracks E0/F0 prefixes, maps make codes, drops releases and stale prefixes.
module ps2_key_mapper #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [4:0]  IDLE_CODE      = 5'd31
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic       start_pressed,
  output logic       seq_error
);

  localparam int unsigned     CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       B_E0      = 8'hE0;
  localparam logic [7:0]       B_F0      = 8'hF0;
  localparam logic [4:0]       START_CODE = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GOT_E0,
    S_GOT_F0,
    S_GOT_E0F0
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } map_t;

  // Code = 4*player + dir, dir: 00 up, 01 down, 10 left, 11 right.
  function automatic map_t map_normal(input logic [7:0] b);
    map_t m;
    m.hit  = 1'b1;
    m.code = 5'd0;
    case (b)
      8'h1D:   m.code = 5'd0;
      8'h1B:   m.code = 5'd1;
      8'h1C:   m.code = 5'd2;
      8'h23:   m.code = 5'd3;
      8'h2C:   m.code = 5'd4;
      8'h34:   m.code = 5'd5;
      8'h2B:   m.code = 5'd6;
      8'h33:   m.code = 5'd7;
      8'h43:   m.code = 5'd8;
      8'h42:   m.code = 5'd9;
      8'h3B:   m.code = 5'd10;
      8'h4B:   m.code = 5'd11;
      8'h29:   m.code = START_CODE;
      default: m.hit  = 1'b0;
    endcase
    return m;
  endfunction

  function automatic map_t map_ext(input logic [7:0] b);
    map_t m;
    m.hit  = 1'b1;
    m.code = 5'd0;
    case (b)
      8'h75:   m.code = 5'd12;
      8'h72:   m.code = 5'd13;
      8'h6B:   m.code = 5'd14;
      8'h74:   m.code = 5'd15;
      default: m.hit  = 1'b0;
    endcase
    return m;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_e0, is_f0, timeout;
  map_t             nrm, ext;
  logic             load_d, err_d;
  logic [4:0]       code_d;

  assign is_e0 = (ps2_byte == B_E0);
  assign is_f0 = (ps2_byte == B_F0);
  assign nrm   = map_normal(ps2_byte);
  assign ext   = map_ext(ps2_byte);

  // A strobe in the expiry cycle takes priority over the timeout.
  assign timeout = (state_q != S_IDLE) && !ps2_byte_valid && (cnt_q == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || ps2_byte_valid || timeout || state_q == S_IDLE) cnt_q <= '0;
    else                                                          cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (ps2_byte_valid) begin
      case (state_q)
        S_IDLE: begin
          if (is_e0)      state_d = S_GOT_E0;
          else if (is_f0) state_d = S_GOT_F0;
        end
        S_GOT_E0: begin
          if (is_f0)      state_d = S_GOT_E0F0;
          else if (is_e0) state_d = S_GOT_E0;
          else            state_d = S_IDLE;
        end
        default:          state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    load_d = 1'b0;
    code_d = nrm.code;
    err_d  = timeout;
    if (ps2_byte_valid) begin
      case (state_q)
        S_IDLE: begin
          load_d = nrm.hit;
          code_d = nrm.code;
        end
        S_GOT_E0: begin
          load_d = ext.hit;
          code_d = ext.code;
        end
        default: load_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      KEY_PRESSED   <= IDLE_CODE;
      key_valid     <= 1'b0;
      start_pressed <= 1'b0;
      seq_error     <= 1'b0;
    end else begin
      key_valid     <= load_d;
      start_pressed <= load_d && (code_d == START_CODE);
      seq_error     <= err_d;
      if (load_d) KEY_PRESSED <= code_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper with a short prefix timeout (8 cycles).
module tb_ps2_key_mapper;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_byte_valid = 1'b0;
  logic [4:0] KEY_PRESSED;
  logic       key_valid, start_pressed, seq_error;

  int total = 0;
  int bad   = 0;
  int kv_n = 0, sp_n = 0, se_n = 0;

  ps2_key_mapper #(.TIMEOUT_CYCLES(8), .IDLE_CODE(5'd31)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .ps2_byte      (ps2_byte),
    .ps2_byte_valid(ps2_byte_valid),
    .KEY_PRESSED   (KEY_PRESSED),
    .key_valid     (key_valid),
    .start_pressed (start_pressed),
    .seq_error     (seq_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Pulse counters: each posedge tallies the cycle that just ended.
  always @(posedge CLOCK_50) begin
    if (key_valid === 1'b1)     kv_n <= kv_n + 1;
    if (start_pressed === 1'b1) sp_n <= sp_n + 1;
    if (seq_error === 1'b1)     se_n <= se_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the next negedge, after the consuming edge.
  task automatic send(input logic [7:0] b);
    ps2_byte       = b;
    ps2_byte_valid = 1'b1;
    @(negedge CLOCK_50);
    ps2_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    int kv0, se0, sp0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    kv0 = kv_n; se0 = se_n; sp0 = sp_n;
    idle(10);
    total++; if (KEY_PRESSED !== 5'd31) begin bad++; $display("FAIL reset_key got=%0d exp=31", KEY_PRESSED); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_kv got=%b exp=0", key_valid); end
    total++; if (kv_n - kv0 != 0) begin bad++; $display("FAIL reset_kv_pulses got=%0d exp=0", kv_n - kv0); end
    total++; if ((se_n - se0) + (sp_n - sp0) != 0) begin bad++; $display("FAIL reset_other_pulses got=%0d exp=0", (se_n - se0) + (sp_n - sp0)); end
  endtask

  task automatic test_normal;
    int kv0;
    kv0 = kv_n;
    send(8'h1D);
    total++; if (KEY_PRESSED !== 5'd0 || key_valid !== 1'b1) begin bad++; $display("FAIL normal_w got=%0d/%b exp=0/1", KEY_PRESSED, key_valid); end
    idle(5);
    send(8'h1C);
    total++; if (KEY_PRESSED !== 5'd2 || key_valid !== 1'b1) begin bad++; $display("FAIL normal_a got=%0d/%b exp=2/1", KEY_PRESSED, key_valid); end
    idle(5);
    total++; if (KEY_PRESSED !== 5'd2 || key_valid !== 1'b0) begin bad++; $display("FAIL normal_hold got=%0d/%b exp=2/0", KEY_PRESSED, key_valid); end
    total++; if (kv_n - kv0 != 2) begin bad++; $display("FAIL normal_pulses got=%0d exp=2", kv_n - kv0); end
  endtask

  task automatic test_extended;
    int kv0;
    kv0 = kv_n;
    send(8'hE0);
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ext_prefix_kv got=%b exp=0", key_valid); end
    idle(2);
    send(8'h74);
    total++; if (KEY_PRESSED !== 5'd15 || key_valid !== 1'b1) begin bad++; $display("FAIL ext_right got=%0d/%b exp=15/1", KEY_PRESSED, key_valid); end
    idle(2);
    send(8'hE0); idle(1);
    send(8'hF0); idle(1);
    send(8'h74);
    total++; if (KEY_PRESSED !== 5'd15 || key_valid !== 1'b0) begin bad++; $display("FAIL ext_release got=%0d/%b exp=15/0", KEY_PRESSED, key_valid); end
    idle(2);
    total++; if (kv_n - kv0 != 1) begin bad++; $display("FAIL ext_pulses got=%0d exp=1", kv_n - kv0); end
  endtask

  task automatic test_release;
    int kv0, sp0;
    kv0 = kv_n; sp0 = sp_n;
    send(8'hF0); idle(1);
    send(8'h23);
    total++; if (KEY_PRESSED !== 5'd15 || key_valid !== 1'b0) begin bad++; $display("FAIL rel_d got=%0d/%b exp=15/0", KEY_PRESSED, key_valid); end
    idle(2);
    send(8'h29);
    total++; if (KEY_PRESSED !== 5'd16 || key_valid !== 1'b1 || start_pressed !== 1'b1) begin bad++; $display("FAIL start got=%0d/%b/%b exp=16/1/1", KEY_PRESSED, key_valid, start_pressed); end
    idle(2);
    total++; if (kv_n - kv0 != 1 || sp_n - sp0 != 1) begin bad++; $display("FAIL start_pulses got=%0d/%0d exp=1/1", kv_n - kv0, sp_n - sp0); end
  endtask

  task automatic test_timeout;
    int kv0, se0;
    kv0 = kv_n; se0 = se_n;
    send(8'hE0);
    idle(8);
    total++; if (seq_error !== 1'b1) begin bad++; $display("FAIL timeout_pulse got=%b exp=1", seq_error); end
    send(8'h75);
    total++; if (KEY_PRESSED !== 5'd16 || key_valid !== 1'b0 || seq_error !== 1'b0) begin bad++; $display("FAIL timeout_after got=%0d/%b/%b exp=16/0/0", KEY_PRESSED, key_valid, seq_error); end
    idle(2);
    total++; if (se_n - se0 != 1 || kv_n - kv0 != 0) begin bad++; $display("FAIL timeout_pulses got=%0d/%0d exp=1/0", se_n - se0, kv_n - kv0); end
  endtask

  task automatic test_timeout_boundary;
    int se0;
    se0 = se_n;
    send(8'hE0);
    idle(7);
    send(8'h75);
    total++; if (KEY_PRESSED !== 5'd12 || key_valid !== 1'b1) begin bad++; $display("FAIL boundary_load got=%0d/%b exp=12/1", KEY_PRESSED, key_valid); end
    idle(10);
    total++; if (se_n - se0 != 0) begin bad++; $display("FAIL boundary_err got=%0d exp=0", se_n - se0); end
  endtask

  task automatic test_unmapped;
    int kv0;
    kv0 = kv_n;
    send(8'h55);
    total++; if (KEY_PRESSED !== 5'd12 || key_valid !== 1'b0) begin bad++; $display("FAIL unmapped got=%0d/%b exp=12/0", KEY_PRESSED, key_valid); end
    send(8'hE0);
    send(8'h1D);
    total++; if (KEY_PRESSED !== 5'd12 || key_valid !== 1'b0) begin bad++; $display("FAIL ext_discard got=%0d/%b exp=12/0", KEY_PRESSED, key_valid); end
    send(8'hE0);
    send(8'hE0);
    send(8'h72);
    total++; if (KEY_PRESSED !== 5'd13 || key_valid !== 1'b1) begin bad++; $display("FAIL e0_e0_down got=%0d/%b exp=13/1", KEY_PRESSED, key_valid); end
    idle(2);
    total++; if (kv_n - kv0 != 1) begin bad++; $display("FAIL unmapped_pulses got=%0d exp=1", kv_n - kv0); end
  endtask

  task automatic test_back_to_back;
    int kv0;
    kv0 = kv_n;
    ps2_byte = 8'h1B; ps2_byte_valid = 1'b1;
    @(negedge CLOCK_50);
    total++; if (KEY_PRESSED !== 5'd1 || key_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%0d/%b exp=1/1", KEY_PRESSED, key_valid); end
    ps2_byte = 8'h4B;
    @(negedge CLOCK_50);
    total++; if (KEY_PRESSED !== 5'd11 || key_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got=%0d/%b exp=11/1", KEY_PRESSED, key_valid); end
    @(negedge CLOCK_50);
    total++; if (KEY_PRESSED !== 5'd11 || key_valid !== 1'b1) begin bad++; $display("FAIL typematic got=%0d/%b exp=11/1", KEY_PRESSED, key_valid); end
    ps2_byte_valid = 1'b0;
    idle(2);
    total++; if (kv_n - kv0 != 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", kv_n - kv0); end
  endtask

  task automatic test_reset_mid;
    int se0;
    send(8'hF0);
    se0 = se_n;
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    total++; if (KEY_PRESSED !== 5'd31 || key_valid !== 1'b0) begin bad++; $display("FAIL midreset got=%0d/%b exp=31/0", KEY_PRESSED, key_valid); end
    send(8'h42);
    total++; if (KEY_PRESSED !== 5'd9 || key_valid !== 1'b1) begin bad++; $display("FAIL midreset_k got=%0d/%b exp=9/1", KEY_PRESSED, key_valid); end
    idle(12);
    total++; if (se_n - se0 != 0) begin bad++; $display("FAIL midreset_err got=%0d exp=0", se_n - se0); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_extended();
    test_release();
    test_timeout();
    test_timeout_boundary();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
